// File: rtl/bytecode_pkg.sv
// Shared definitions for the bytecode fetch/execute pair: byte widths, opcodes,
// FSM states, fault codes and the opcode classification helper.
package bytecode_pkg;

    localparam int BYTE        = 8;
    localparam int WIDTH_IN    = 16;
    localparam int DATA_WIDTH  = 32;
    localparam int STACK_DEPTH = 16;
    localparam int PTR_W       = $clog2(STACK_DEPTH);
    localparam int DEPTH_W     = PTR_W + 1;

    localparam logic [BYTE-1:0] OP_NOP       = 8'h00;
    localparam logic [BYTE-1:0] OP_ICONST_M1 = 8'h02;
    localparam logic [BYTE-1:0] OP_ICONST_5  = 8'h08;
    localparam logic [BYTE-1:0] OP_BIPUSH    = 8'h10;
    localparam logic [BYTE-1:0] OP_POP       = 8'h57;
    localparam logic [BYTE-1:0] OP_DUP       = 8'h59;
    localparam logic [BYTE-1:0] OP_SWAP      = 8'h5F;
    localparam logic [BYTE-1:0] OP_IADD      = 8'h60;
    localparam logic [BYTE-1:0] OP_ISUB      = 8'h64;
    localparam logic [BYTE-1:0] OP_IMUL      = 8'h68;
    localparam logic [BYTE-1:0] OP_INEG      = 8'h74;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_MUL,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        ERR_UNSUPPORTED = 2'b00,
        ERR_OVERFLOW    = 2'b01,
        ERR_UNDERFLOW   = 2'b10,
        ERR_RESERVED    = 2'b11
    } err_code_e;

    typedef struct packed {
        logic       supported;
        logic [1:0] pops;
        logic [1:0] pushes;
        logic [1:0] len;
    } op_info_t;

    // Stack effect of an opcode: entries consumed, entries produced, bytes used.
    function automatic op_info_t decode_op(input logic [BYTE-1:0] op, input logic imul_en);
        op_info_t info;
        info.supported = 1'b1;
        info.pops      = 2'd0;
        info.pushes    = 2'd0;
        info.len       = 2'd1;
        if (op >= OP_ICONST_M1 && op <= OP_ICONST_5) begin
            info.pushes = 2'd1;
        end else begin
            case (op)
                OP_NOP: ;
                OP_BIPUSH: begin
                    info.pushes = 2'd1;
                    info.len    = 2'd2;
                end
                OP_POP: info.pops = 2'd1;
                OP_DUP: begin
                    info.pops   = 2'd1;
                    info.pushes = 2'd2;
                end
                OP_SWAP: begin
                    info.pops   = 2'd2;
                    info.pushes = 2'd2;
                end
                OP_IADD, OP_ISUB: begin
                    info.pops   = 2'd2;
                    info.pushes = 2'd1;
                end
                OP_IMUL: begin
                    info.pops      = 2'd2;
                    info.pushes    = 2'd1;
                    info.supported = imul_en;
                end
                OP_INEG: begin
                    info.pops   = 2'd1;
                    info.pushes = 2'd1;
                end
                default: info.supported = 1'b0;
            endcase
        end
        return info;
    endfunction

endpackage

// File: rtl/bytecode_decoder_if.sv
// Fetch-to-execute handshake plus the status/debug outputs of the decoder.
interface bytecode_decoder_if;
    import bytecode_pkg::*;

    logic                  start_from_fetch;
    logic [WIDTH_IN-1:0]   data_from_fetch;
    logic                  ready_for_decoder;
    logic                  done;
    logic [1:0]            instr_len;
    logic [DATA_WIDTH-1:0] tos;
    logic [DEPTH_W-1:0]    depth;
    logic                  error;
    logic [1:0]            err_code;

    modport master (
        output start_from_fetch, data_from_fetch,
        input  ready_for_decoder, done, instr_len, tos, depth, error, err_code
    );

    modport slave (
        input  start_from_fetch, data_from_fetch,
        output ready_for_decoder, done, instr_len, tos, depth, error, err_code
    );

endinterface

// File: rtl/seq_multiplier.sv
// Shift-add multiplier, one multiplier bit per cycle for W cycles; returns the
// low W bits of a*b. done is high during the final step.
module seq_multiplier #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] product
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  mcand_q;
    logic [W-1:0]  mplier_q;
    logic [W-1:0]  acc_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (start && !busy) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= CW'(W);
        end else if (busy) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q - CW'(1);
        end
    end

    assign busy    = (count_q != '0);
    assign done    = (count_q == CW'(1));
    assign product = acc_q;

endmodule

// File: rtl/bytecode_decoder.sv
// Executes a JVM integer subset against a private operand stack; halts on fault.
// Define BYTECODE_IMUL_EN to support imul (0x68) through seq_multiplier.
module bytecode_decoder
    import bytecode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    bytecode_decoder_if.slave bus
);
`ifdef BYTECODE_IMUL_EN
    localparam logic IMUL_EN = 1'b1;
`else
    localparam logic IMUL_EN = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [BYTE-1:0]       op_q, imm_q;
    logic                  error_q;
    err_code_e             err_code_q;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic [DATA_WIDTH-1:0] stack_q [STACK_DEPTH];

    op_info_t              info;
    logic [PTR_W-1:0]      push_idx, top_idx, next_idx;
    logic [DATA_WIDTH-1:0] top_val, next_val;
    logic                  fault;
    err_code_e             fault_code;
    logic                  mul_start, mul_done;
    logic [DATA_WIDTH-1:0] mul_product;
    logic                  wr0_en, wr1_en;
    logic [PTR_W-1:0]      wr0_idx, wr1_idx;
    logic [DATA_WIDTH-1:0] wr0_data, wr1_data;
    logic [BYTE-1:0]       const_val;
    logic                  done_w;

    assign info     = decode_op(op_q, IMUL_EN);
    assign push_idx = depth_q[PTR_W-1:0];
    assign top_idx  = push_idx - PTR_W'(1);
    assign next_idx = push_idx - PTR_W'(2);
    assign top_val  = stack_q[top_idx];
    assign next_val = stack_q[next_idx];

`ifdef BYTECODE_IMUL_EN
    logic mul_busy_unused;

    seq_multiplier #(.W(DATA_WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (top_val),
        .b       (next_val),
        .busy    (mul_busy_unused),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    logic mul_start_unused;
    assign mul_start_unused = mul_start;
    assign mul_done         = 1'b1;
    assign mul_product      = '0;
`endif

    always_comb begin
        fault      = 1'b0;
        fault_code = ERR_UNSUPPORTED;
        if (!info.supported) begin
            fault = 1'b1;
        end else if (DEPTH_W'(info.pops) > depth_q) begin
            fault      = 1'b1;
            fault_code = ERR_UNDERFLOW;
        end else if (info.pushes > info.pops && depth_q == DEPTH_W'(STACK_DEPTH)) begin
            fault      = 1'b1;
            fault_code = ERR_OVERFLOW;
        end
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE:   if (bus.start_from_fetch) state_d = ST_DECODE;
            ST_DECODE: begin
                if (fault) begin
                    state_d = ST_HALT;
                end else if (op_q == OP_IMUL) begin
                    state_d   = ST_MUL;
                    mul_start = 1'b1;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MUL:    if (mul_done) state_d = ST_WB;
            ST_WB:     state_d = ST_IDLE;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Up to two stack entries change per instruction (swap); depth moves by the net effect.
    always_comb begin
        wr0_en    = 1'b0;
        wr0_idx   = push_idx;
        wr0_data  = top_val;
        wr1_en    = 1'b0;
        wr1_idx   = next_idx;
        wr1_data  = top_val;
        const_val = op_q - 8'd3;
        depth_d   = depth_q - DEPTH_W'(info.pops) + DEPTH_W'(info.pushes);
        if (op_q >= OP_ICONST_M1 && op_q <= OP_ICONST_5) begin
            wr0_en   = 1'b1;
            wr0_data = {{(DATA_WIDTH-BYTE){const_val[BYTE-1]}}, const_val};
        end else begin
            case (op_q)
                OP_BIPUSH: begin
                    wr0_en   = 1'b1;
                    wr0_data = {{(DATA_WIDTH-BYTE){imm_q[BYTE-1]}}, imm_q};
                end
                OP_DUP: wr0_en = 1'b1;
                OP_SWAP: begin
                    wr0_en   = 1'b1;
                    wr0_idx  = top_idx;
                    wr0_data = next_val;
                    wr1_en   = 1'b1;
                end
                OP_IADD: begin
                    wr0_en   = 1'b1;
                    wr0_idx  = next_idx;
                    wr0_data = next_val + top_val;
                end
                OP_ISUB: begin
                    wr0_en   = 1'b1;
                    wr0_idx  = next_idx;
                    wr0_data = next_val - top_val;
                end
                OP_IMUL: begin
                    wr0_en   = 1'b1;
                    wr0_idx  = next_idx;
                    wr0_data = mul_product;
                end
                OP_INEG: begin
                    wr0_en   = 1'b1;
                    wr0_idx  = top_idx;
                    wr0_data = '0 - top_val;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            imm_q      <= '0;
            error_q    <= 1'b0;
            err_code_q <= ERR_UNSUPPORTED;
            depth_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && bus.start_from_fetch) begin
                op_q  <= bus.data_from_fetch[WIDTH_IN-1:BYTE];
                imm_q <= bus.data_from_fetch[BYTE-1:0];
            end
            if (state_q == ST_DECODE && fault) begin
                error_q    <= 1'b1;
                err_code_q <= fault_code;
            end
            if (state_q == ST_WB) begin
                depth_q <= depth_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else if (state_q == ST_WB) begin
            if (wr0_en) stack_q[wr0_idx] <= wr0_data;
            if (wr1_en) stack_q[wr1_idx] <= wr1_data;
        end
    end

    assign done_w                = (state_q == ST_WB);
    assign bus.ready_for_decoder = (state_q == ST_IDLE);
    assign bus.done              = done_w;
    assign bus.instr_len         = done_w ? info.len : 2'd0;
    assign bus.tos               = (depth_q == '0) ? '0 : top_val;
    assign bus.depth             = depth_q;
    assign bus.error             = error_q;
    assign bus.err_code          = err_code_q;

endmodule
